imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, output word width; legal only when OUT_W >= IN_W+2.
REQ-003 Parameter TAG_W, default 5, width of the pass-through tag, e.g. destination register.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  upstream offers an immediate this cycle.
REQ-007 in_ready  output  1  block accepts an immediate this cycle; driven from a register.
REQ-008 in_imm  input  IN_W  raw immediate field.
REQ-009 in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-010 in_tag  input  TAG_W  carried unchanged to out_tag.
REQ-011 out_valid  output  1  out_word and out_tag hold a result.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 out_word  output  OUT_W  extended result.
REQ-014 out_tag  output  TAG_W  tag of the current result.

Function
REQ-015 The transfer rules SHALL be: input accepted when in_valid and in_ready; output consumed when out_valid and out_ready.
REQ-016 Mode 00 SHALL zero-fill the upper OUT_W-IN_W bits.
REQ-017 Mode 01 SHALL replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
REQ-018 Mode 10 SHALL place in_imm in bits [OUT_W-1:OUT_W-IN_W] and zero the low bits.
REQ-019 Mode 11 SHALL sign-extend, then shift left by 2 with zero fill; no bits are lost, given REQ-002.
REQ-020 The result SHALL be computed at accept time and registered, giving 1-cycle latency from accept to out_valid.
REQ-021 Storage SHALL be a main register (drives outputs) plus one skid register; capacity is 2 results.
REQ-022 The states SHALL be EMPTY (none valid), ONE (main valid), and FULL (main and skid valid).
REQ-023 EMPTY transitions: accept -> ONE; otherwise stay.
REQ-024 ONE transitions:
  - accept with no consume -> FULL, result into skid;
  - accept with consume -> ONE, main reloaded;
  - consume only -> EMPTY.
REQ-025 FULL transitions: consume -> ONE, skid moves to main; accept is impossible.
REQ-026 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it is a registered state decode with no combinational path from out_ready.
REQ-027 Results SHALL leave in strict acceptance order; none dropped or duplicated.
REQ-028 out_word and out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Sustained in_valid=1 with out_ready=1 SHALL give one result per cycle.
REQ-030 in_* values SHALL be ignored when no accept occurs; out_word/out_tag are don't-care when out_valid=0.

Reset
REQ-031 With Rst=0 at a rising edge: state EMPTY, out_valid=0, out_word=0, out_tag=0, in_ready=0.
REQ-032 in_ready SHALL rise on the first edge after Rst returns to 1.
REQ-033 Reset mid-operation SHALL discard all held results; no accept occurs in a reset cycle.

Structure
REQ-034 The mode encodings and state encodings SHALL live in shared package ext_pkg.
REQ-035 The combinational extender SHALL be sub-module ext_core (imm, mode -> word, parametrised IN_W/OUT_W), instantiated once at the input side.
REQ-036 Parameter legality (REQ-002) SHALL be checked at elaboration; an illegal combination fails the build.

Verification
REQ-037 Sign mode: IN_W=16, OUT_W=32, mode 01, imm 0x8000 -> out_word 0xFFFF8000 one cycle later; imm 0x7FFF -> 0x00007FFF.
REQ-038 Zero and upper modes: mode 00, imm 0x8000 -> 0x00008000; mode 10, imm 0x1234 -> 0x12340000.
REQ-039 Branch mode: mode 11, imm 0xFFFF -> 0xFFFFFFFC; imm 0x0004 -> 0x00000010.
REQ-040 Backpressure:
  - stimulus: out_ready=0; push tags 1, 2; then hold out_ready=0 for 3 cycles;
  - response: in_ready=0 after the 2nd accept; outputs stable;
  - release: out_ready=1 -> tags 1, 2 in order, in_ready back to 1.
REQ-041 Streaming: 8 back-to-back pushes with out_ready=1 -> 8 results on consecutive cycles, tags in order.
REQ-042 Reset mid-op: FULL state, Rst=0 one cycle -> out_valid=0, out_word=0, out_tag=0; no stale result after Rst=1.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared encodings for the immediate extension pipe: extension modes and
// the skid-buffer occupancy states.
package ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } ext_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } ext_state_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus carrying raw immediates in and extended words out.
// master = producer/consumer side (testbench), slave = the pipe.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_word, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_word, out_tag
  );
endinterface

// File: rtl/ext_core.sv
// Combinational immediate extender: zero, sign, upper and branch
// (sign-extend then scale by 4) forms.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] word
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  // Select the extension form; branch drops only the two copied sign bits.
  always_comb begin
    word = '0;
    unique case (ext_mode_e'(mode))
      MODE_ZERO:   word = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_SIGN:   word = sext;
      MODE_UPPER:  word = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: word = sext << 2;
      default:     word = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension stage: extends at accept time into a main output
// register, with one skid entry so in_ready can be a pure registered decode.
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,   // synchronous, active low
  imm_extend_pipe_if.slave bus
);

  // Branch mode needs two spare bits above the sign-extended immediate.
  if (OUT_W < IN_W + 2) begin : g_bad_params
    $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
  end

  ext_state_e       state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] main_word, skid_word;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic [OUT_W-1:0] ext_word;
  logic             accept, consume;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .word (ext_word)
  );

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = main_word;
  assign bus.out_tag   = main_tag;

  // Occupancy FSM; in_ready/out_valid are registered with the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_word   <= '0;
      main_tag    <= '0;
      skid_word   <= '0;
      skid_tag    <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            main_word   <= ext_word;
            main_tag    <= bus.in_tag;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !consume) begin
            skid_word  <= ext_word;
            skid_tag   <= bus.in_tag;
            in_ready_q <= 1'b0;
            state      <= ST_FULL;
          end else if (accept && consume) begin
            main_word <= ext_word;
            main_tag  <= bus.in_tag;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can coincide.
          if (consume) begin
            main_word  <= skid_word;
            main_tag   <= skid_tag;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: extension modes, backpressure,
// streaming and mid-operation reset.
module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm,
                       input logic [4:0] t);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_imm   = imm;
    bus.in_tag   = t;
  endtask

  // Mode vectors: mode, imm, expected word.
  logic [1:0]  v_mode [7];
  logic [15:0] v_imm  [7];
  logic [31:0] v_exp  [7];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    v_mode[0] = 2'b01; v_imm[0] = 16'h8000; v_exp[0] = 32'hFFFF8000;
    v_mode[1] = 2'b01; v_imm[1] = 16'h7FFF; v_exp[1] = 32'h00007FFF;
    v_mode[2] = 2'b00; v_imm[2] = 16'h8000; v_exp[2] = 32'h00008000;
    v_mode[3] = 2'b10; v_imm[3] = 16'h1234; v_exp[3] = 32'h12340000;
    v_mode[4] = 2'b11; v_imm[4] = 16'hFFFF; v_exp[4] = 32'hFFFFFFFC;
    v_mode[5] = 2'b11; v_imm[5] = 16'h0004; v_exp[5] = 32'h00000010;
    v_mode[6] = 2'b11; v_imm[6] = 16'h8001; v_exp[6] = 32'hFFFE0004;

    // Reset state
    rst = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_word",  64'(bus.out_word),  64'd0);
    chk("rst_out_tag",   64'(bus.out_tag),   64'd0);

    rst = 1'b1;
    step();
    chk("in_ready_rise", 64'(bus.in_ready), 64'd1);

    // Extension modes, one result at a time
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, v_mode[i], v_imm[i], 5'(i + 1));
      bus.out_ready = 1'b0;
      step();
      drive(1'b0, 2'b00, 16'hDEAD, 5'd31);
      chk($sformatf("mode%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("mode%0d_word", i),  64'(bus.out_word),  64'(v_exp[i]));
      chk($sformatf("mode%0d_tag", i),   64'(bus.out_tag),   64'(i + 1));
      bus.out_ready = 1'b1;
      step();
      chk($sformatf("mode%0d_drain", i), 64'(bus.out_valid), 64'd0);
    end

    // Backpressure: two accepts fill main + skid
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0001, 5'd1);
    step();
    chk("bp_first_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 2'b00, 16'h0002, 5'd2);
    step();
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 2'b00, 16'h0003, 5'd3);  // must be ignored while full
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_tag",   64'(bus.out_tag),  64'd1);
      chk("bp_hold_word",  64'(bus.out_word), 64'h1);
    end
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_rel_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_rel_tag",   64'(bus.out_tag),   64'd2);
    chk("bp_rel_word",  64'(bus.out_word),  64'h2);
    chk("bp_rel_ready", 64'(bus.in_ready),  64'd1);
    step();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Streaming: one result per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b00, 16'(i * 3), 5'(i + 8));
      step();
      chk("st_valid", 64'(bus.out_valid), 64'd1);
      chk("st_tag",   64'(bus.out_tag),   64'(i + 8));
      chk("st_word",  64'(bus.out_word),  64'(i * 3));
      chk("st_ready", 64'(bus.in_ready),  64'd1);
    end
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    step();
    chk("st_drain", 64'(bus.out_valid), 64'd0);

    // Reset with both entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 16'hABCD, 5'd20);
    step();
    drive(1'b1, 2'b10, 16'h1111, 5'd21);
    step();
    chk("mr_full", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    drive(1'b1, 2'b01, 16'h5555, 5'd22);
    step();
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_word",  64'(bus.out_word),  64'd0);
    chk("mr_out_tag",   64'(bus.out_tag),   64'd0);
    chk("mr_in_ready",  64'(bus.in_ready),  64'd0);
    rst = 1'b1;
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    step();
    chk("mr_post_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_post_ready", 64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("mr_no_stale", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 2'b11, 16'h0004, 5'd5);
    step();
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    chk("mr_new_word", 64'(bus.out_word), 64'h10);
    chk("mr_new_tag",  64'(bus.out_tag),  64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
